// File: rtl/gain_pkg.sv
// Shared gain-code definitions for the AGC loop and any gain UI.
// Codes are signed 4-bit: -8 is mute, 0 is unity, 7 is the loudest setting.
package gain_pkg;

  localparam logic [3:0] GAIN_MUTE  = 4'b1000;
  localparam logic [3:0] GAIN_UNITY = 4'b0000;
  localparam logic [3:0] GAIN_MAX   = 4'b0111;

  typedef enum logic [1:0] {
    ACCUM,
    DECIDE,
    MANUAL
  } state_t;

  // Signed step with saturation. The result always lands in [lo, hi].
  // A code that starts outside the range is therefore pulled back inside.
  function automatic logic [3:0] sat_step(input logic [3:0] code, input int delta,
                                          input int lo, input int hi);
    int v;
    v = int'($signed(code)) + delta;
    if (v < lo) begin
      v = lo;
    end else if (v > hi) begin
      v = hi;
    end
    return v[3:0];
  endfunction

endpackage

// File: rtl/peak_detector.sv
// Windowed peak and clip measurement on accepted samples; window_done flags the sample closing the window.
// Window results register on that same edge; never stalls the stream, clear holds the window empty.
module peak_detector #(
  parameter int W        = 16,
  parameter int WINDOW   = 256,
  parameter int CLIP_THR = 32000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         sample_valid,
  input  logic [W-1:0] sound_in,
  output logic         window_done,
  output logic [W-1:0] win_peak,
  output logic         win_clip
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] LAST   = CW'(WINDOW - 1);
  localparam logic [W-1:0]  CLIP_T = W'(CLIP_THR);
  localparam logic [W-1:0]  NEG_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  POS_MAX = {1'b0, {(W-1){1'b1}}};

  logic [CW-1:0] count;
  logic [W-1:0]  peak;
  logic          clip_flag;
  logic [W-1:0]  mag;
  logic [W-1:0]  peak_in;
  logic          clip_in;

  always_comb begin
    mag = sound_in;
    // The most negative value has no positive twin; pin it to full scale.
    if (sound_in == NEG_MIN) begin
      mag = POS_MAX;
    end else if (sound_in[W-1]) begin
      mag = ~sound_in + 1'b1;
    end
    peak_in     = (mag > peak) ? mag : peak;
    clip_in     = clip_flag | (mag >= CLIP_T);
    window_done = sample_valid && !clear && (count == LAST);
  end

  // The running state empties on the closing edge, so a sample arriving one
  // cycle later naturally opens the next window with peak = its magnitude.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      count     <= '0;
      peak      <= '0;
      clip_flag <= 1'b0;
    end else if (sample_valid) begin
      if (count == LAST) begin
        count     <= '0;
        peak      <= '0;
        clip_flag <= 1'b0;
      end else begin
        count     <= count + 1'b1;
        peak      <= peak_in;
        clip_flag <= clip_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      win_peak <= '0;
      win_clip <= 1'b0;
    end else if (window_done) begin
      win_peak <= peak_in;
      win_clip <= clip_in;
    end
  end

endmodule

// File: rtl/gain_controller.sv
// AGC loop: steps a signed 4-bit gain from windowed peak/clip measurements, with manual override.
// Gain updates on the edge after the window-closing edge; samples are never stalled.
module gain_controller
  import gain_pkg::*;
#(
  parameter int W            = 16,
  parameter int WINDOW       = 256,
  parameter int HIGH_THR     = 24576,
  parameter int LOW_THR      = 8192,
  parameter int CLIP_THR     = 32000,
  parameter int HOLD_WINDOWS = 4,
  parameter int MIN_GAIN     = -7,
  parameter int MAX_GAIN     = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sample_valid,
  input  logic [W-1:0] sound_in,
  input  logic         manual_en,
  input  logic [3:0]   manual_gain,
  output logic [3:0]   gain,
  output logic         gain_update,
  output logic         clip
);

  localparam int QW = $clog2(HOLD_WINDOWS + 1);
  localparam logic [QW-1:0] HOLD   = QW'(HOLD_WINDOWS);
  localparam logic [W-1:0]  HIGH_T = W'(HIGH_THR);
  localparam logic [W-1:0]  LOW_T  = W'(LOW_THR);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    gain_nxt;
  logic          clip_nxt;
  logic [QW-1:0] quiet;
  logic [QW-1:0] quiet_nxt;
  logic [QW-1:0] quiet_inc;
  logic          det_clear;
  logic          window_done;
  logic [W-1:0]  win_peak;
  logic          win_clip;
  int            delta;

  // Manual mode keeps the measurement window empty, including the entry edge.
  assign det_clear = manual_en || (state == MANUAL);

  peak_detector #(
    .W        (W),
    .WINDOW   (WINDOW),
    .CLIP_THR (CLIP_THR)
  ) u_peak_detector (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (det_clear),
    .sample_valid (sample_valid),
    .sound_in     (sound_in),
    .window_done  (window_done),
    .win_peak     (win_peak),
    .win_clip     (win_clip)
  );

  always_comb begin
    state_nxt = state;
    gain_nxt  = gain;
    clip_nxt  = clip;
    quiet_nxt = quiet;
    quiet_inc = quiet + 1'b1;
    delta     = 0;
    if (manual_en) begin
      state_nxt = MANUAL;
      gain_nxt  = manual_gain;
      clip_nxt  = 1'b0;
      quiet_nxt = '0;
    end else begin
      case (state)
        ACCUM: begin
          if (window_done) begin
            state_nxt = DECIDE;
          end
        end
        DECIDE: begin
          state_nxt = ACCUM;
          clip_nxt  = win_clip;
          quiet_nxt = '0;
          if (win_clip) begin
            delta = -2;
          end else if (win_peak > HIGH_T) begin
            delta = -1;
          end else if (win_peak < LOW_T) begin
            if (quiet_inc == HOLD) begin
              delta = 1;
            end else begin
              quiet_nxt = quiet_inc;
            end
          end
          // Neutral windows leave an out-of-range manual code untouched.
          if (delta != 0) begin
            gain_nxt = sat_step(gain, delta, MIN_GAIN, MAX_GAIN);
          end
        end
        MANUAL: begin
          state_nxt = ACCUM;
          clip_nxt  = 1'b0;
          quiet_nxt = '0;
        end
        default: begin
          state_nxt = ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ACCUM;
      gain        <= GAIN_UNITY;
      gain_update <= 1'b0;
      clip        <= 1'b0;
      quiet       <= '0;
    end else begin
      state       <= state_nxt;
      gain        <= gain_nxt;
      gain_update <= (gain_nxt != gain);
      clip        <= clip_nxt;
      quiet       <= quiet_nxt;
    end
  end

endmodule

// File: tb/tb_gain_controller.sv
// Directed bench for gain_controller with WINDOW=4, HOLD_WINDOWS=2 and default thresholds.
module tb_gain_controller;

  logic        clk;
  logic        reset_n;
  logic        sample_valid;
  logic [15:0] sound_in;
  logic        manual_en;
  logic [3:0]  manual_gain;
  logic [3:0]  gain;
  logic        gain_update;
  logic        clip;

  int checks;
  int failures;

  gain_controller #(
    .W            (16),
    .WINDOW       (4),
    .HIGH_THR     (24576),
    .LOW_THR      (8192),
    .CLIP_THR     (32000),
    .HOLD_WINDOWS (2),
    .MIN_GAIN     (-7),
    .MAX_GAIN     (7)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sound_in     (sound_in),
    .manual_en    (manual_en),
    .manual_gain  (manual_gain),
    .gain         (gain),
    .gain_update  (gain_update),
    .clip         (clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    manual_en    = 1'b0;
    manual_gain  = 4'b0000;
    sample_valid = 1'b0;
    sound_in     = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Four back-to-back samples; the last edge closes the window, valid drops after.
  task automatic feed4(input int a, input int b, input int c, input int d);
    sample_valid = 1'b1;
    sound_in = 16'(a); step();
    sound_in = 16'(b); step();
    sound_in = 16'(c); step();
    sound_in = 16'(d); step();
    sample_valid = 1'b0;
  endtask

  task automatic set_manual(input logic [3:0] code);
    manual_en   = 1'b1;
    manual_gain = code;
    step();
  endtask

  task automatic release_manual();
    manual_en = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    manual_en    = 1'b0;
    manual_gain  = 4'b0000;
    sample_valid = 1'b1;
    sound_in     = 16'd30000;
    step();
    step();
    checks++; if (gain !== 4'b0000) begin failures++; $display("FAIL reset_gain got=%b exp=0000", gain); end
    checks++; if (gain_update !== 1'b0) begin failures++; $display("FAIL reset_update got=%b exp=0", gain_update); end
    checks++; if (clip !== 1'b0) begin failures++; $display("FAIL reset_clip got=%b exp=0", clip); end
    reset_n = 1'b1;
    // Three accepted samples after release must not close a window.
    step(); step(); step();
    sample_valid = 1'b0;
    step(); step();
    checks++; if (gain !== 4'b0000) begin failures++; $display("FAIL reset_partial got=%b exp=0000", gain); end
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    checks++; if (gain !== 4'b1111) begin failures++; $display("FAIL reset_first_window got=%b exp=1111", gain); end
  endtask

  task automatic test_loud();
    do_reset();
    feed4(1000, -30000, 500, 0);
    checks++; if (gain !== 4'b0000) begin failures++; $display("FAIL loud_decide_cycle got=%b exp=0000", gain); end
    step();
    checks++; if (gain !== 4'b1111) begin failures++; $display("FAIL loud_gain got=%b exp=1111", gain); end
    checks++; if (gain_update !== 1'b1) begin failures++; $display("FAIL loud_update got=%b exp=1", gain_update); end
    checks++; if (clip !== 1'b0) begin failures++; $display("FAIL loud_clip got=%b exp=0", clip); end
    step();
    checks++; if (gain_update !== 1'b0) begin failures++; $display("FAIL loud_update_pulse got=%b exp=0", gain_update); end
  endtask

  task automatic test_clip();
    do_reset();
    feed4(100, 200, -32768, 5);
    step();
    checks++; if (gain !== 4'b1110) begin failures++; $display("FAIL clip_gain got=%b exp=1110", gain); end
    checks++; if (clip !== 1'b1) begin failures++; $display("FAIL clip_flag got=%b exp=1", clip); end
    feed4(100, 100, 100, 100);
    checks++; if (clip !== 1'b1) begin failures++; $display("FAIL clip_held got=%b exp=1", clip); end
    step();
    checks++; if (clip !== 1'b0) begin failures++; $display("FAIL clip_cleared got=%b exp=0", clip); end
    checks++; if (gain !== 4'b1110) begin failures++; $display("FAIL clip_after_quiet got=%b exp=1110", gain); end
  endtask

  task automatic test_quiet_hold();
    do_reset();
    feed4(100, 100, 100, 100);
    step();
    checks++; if (gain !== 4'b0000) begin failures++; $display("FAIL quiet_w1_gain got=%b exp=0000", gain); end
    checks++; if (gain_update !== 1'b0) begin failures++; $display("FAIL quiet_w1_update got=%b exp=0", gain_update); end
    feed4(100, 100, 100, 100);
    step();
    checks++; if (gain !== 4'b0001) begin failures++; $display("FAIL quiet_w2_gain got=%b exp=0001", gain); end
    checks++; if (gain_update !== 1'b1) begin failures++; $display("FAIL quiet_w2_update got=%b exp=1", gain_update); end
    set_manual(4'b0111);
    release_manual();
    feed4(100, 100, 100, 100);
    step();
    feed4(100, 100, 100, 100);
    step();
    checks++; if (gain !== 4'b0111) begin failures++; $display("FAIL quiet_max_gain got=%b exp=0111", gain); end
    checks++; if (gain_update !== 1'b0) begin failures++; $display("FAIL quiet_max_update got=%b exp=0", gain_update); end
  endtask

  task automatic test_floor();
    do_reset();
    set_manual(4'b1001);
    checks++; if (gain !== 4'b1001) begin failures++; $display("FAIL floor_manual got=%b exp=1001", gain); end
    release_manual();
    feed4(100, 32767, 0, 0);
    step();
    checks++; if (gain !== 4'b1001) begin failures++; $display("FAIL floor_clip_gain got=%b exp=1001", gain); end
    checks++; if (gain_update !== 1'b0) begin failures++; $display("FAIL floor_clip_update got=%b exp=0", gain_update); end
    checks++; if (clip !== 1'b1) begin failures++; $display("FAIL floor_clip_flag got=%b exp=1", clip); end
    set_manual(4'b1000);
    checks++; if (gain !== 4'b1000) begin failures++; $display("FAIL floor_mute got=%b exp=1000", gain); end
    checks++; if (gain_update !== 1'b1) begin failures++; $display("FAIL floor_mute_update got=%b exp=1", gain_update); end
    checks++; if (clip !== 1'b0) begin failures++; $display("FAIL floor_manual_clip got=%b exp=0", clip); end
    release_manual();
    feed4(100, 100, 100, 100);
    step();
    checks++; if (gain !== 4'b1000) begin failures++; $display("FAIL floor_mute_w1 got=%b exp=1000", gain); end
    feed4(100, 100, 100, 100);
    step();
    checks++; if (gain !== 4'b1001) begin failures++; $display("FAIL floor_mute_w2 got=%b exp=1001", gain); end
    checks++; if (gain_update !== 1'b1) begin failures++; $display("FAIL floor_mute_w2_update got=%b exp=1", gain_update); end
  endtask

  task automatic test_manual_preempt();
    do_reset();
    feed4(30000, 30000, 30000, 30000);
    // DECIDE cycle: override wins over the pending step-down.
    set_manual(4'b0101);
    checks++; if (gain !== 4'b0101) begin failures++; $display("FAIL preempt_gain got=%b exp=0101", gain); end
    checks++; if (gain_update !== 1'b1) begin failures++; $display("FAIL preempt_update got=%b exp=1", gain_update); end
    step();
    checks++; if (gain_update !== 1'b0) begin failures++; $display("FAIL preempt_hold_update got=%b exp=0", gain_update); end
    // Release while samples stream: the release-cycle sample is dropped.
    manual_en    = 1'b0;
    sample_valid = 1'b1;
    sound_in     = 16'd30000;
    step();
    step(); step(); step();
    sample_valid = 1'b0;
    step(); step();
    checks++; if (gain !== 4'b0101) begin failures++; $display("FAIL preempt_restart got=%b exp=0101", gain); end
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    checks++; if (gain !== 4'b0100) begin failures++; $display("FAIL preempt_fresh_window got=%b exp=0100", gain); end
    checks++; if (gain_update !== 1'b1) begin failures++; $display("FAIL preempt_fresh_update got=%b exp=1", gain_update); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    sample_valid = 1'b1;
    sound_in = 16'd100;
    step(); step(); step(); step();
    // This sample lands in the DECIDE cycle and opens the next window.
    sound_in = 16'd30000;
    step();
    checks++; if (gain !== 4'b0000) begin failures++; $display("FAIL b2b_quiet_gain got=%b exp=0000", gain); end
    step(); step(); step();
    sample_valid = 1'b0;
    step();
    checks++; if (gain !== 4'b1111) begin failures++; $display("FAIL b2b_loud_gain got=%b exp=1111", gain); end
    checks++; if (gain_update !== 1'b1) begin failures++; $display("FAIL b2b_loud_update got=%b exp=1", gain_update); end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sound_in     = '0;
    manual_en    = 1'b0;
    manual_gain  = 4'b0000;
    test_reset();
    test_loud();
    test_clip();
    test_quiet_hold();
    test_floor();
    test_manual_preempt();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
